// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: redirect, memory request/response and core-facing instruction channels
interface ifetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [29:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetcher with credit-limited queue and redirect flush
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rstn,
    ifetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [CW:0]   credit;
    logic [31:0]   redir_pc;
    logic          redir, req_fire, rsp, push, pop;

    // Requests are gated during reset so nothing is handed to a memory that is itself resetting
    assign redir    = bus.redirect_valid;
    assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
    assign credit   = {1'b0, count_q} + {1'b0, outst_q};
    assign rsp      = bus.mem_rsp_valid;

    assign bus.mem_req_valid = rstn && !redir && (credit < LIMIT);
    assign bus.mem_req_addr  = fetch_pc_q[31:2];
    assign bus.out_valid     = count_q != '0;
    assign bus.out_instr     = bus.out_valid ? instr_q[head_q] : '0;
    assign bus.out_pc        = bus.out_valid ? pc_q[head_q] : '0;

    assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
    assign pop      = bus.out_valid && bus.out_ready && !redir;
    assign push     = rsp && drop_q == '0 && !redir;

    // Next state: a redirect empties the queue and marks every still-pending response as stale
    always_comb begin
        outst_d    = outst_q + CW'(req_fire) - CW'(rsp);
        drop_d     = redir ? outst_q - CW'(rsp) : drop_q - CW'(rsp && drop_q != '0);
        fetch_pc_d = redir ? redir_pc : fetch_pc_q + (req_fire ? 32'd4 : 32'd0);
        rsp_pc_d   = redir ? redir_pc : rsp_pc_q + (push ? 32'd4 : 32'd0);
        count_d    = redir ? '0 : count_q + CW'(push) - CW'(pop);
        head_d     = redir ? '0 : head_q + AW'(pop);
        tail_d     = redir ? '0 : tail_q + AW'(push);
    end

    // Control state registers; the credit rule makes a push into a full queue impossible
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            assert (!(push && !pop && count_q == CW'(DEPTH)));
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage; contents are only visible while count is non-zero, so no reset is needed
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            instr_q[tail_q] <= bus.mem_rsp_data;
            pc_q[tail_q]    <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and random stimulus checked against an epoch-tagged fetch model
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [29:0] addr;
        int          ep;
        int          due;
    } req_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    ifetch_queue_if bus ();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    req_t        mq[$];
    logic [31:0] eq[$];
    logic [31:0] fpc = RESET_PC;
    int          ep = 0;
    int          cyc = 0;
    int          vecs = 0;
    int          errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] rp, input logic mr, input logic ordy, input int lat);
        logic  rsp, exp_req, fire, pop;
        req_t  r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.mem_req_ready  = mr;
        bus.out_ready      = ordy;
        rsp = mq.size() > 0 && mq[0].due <= cyc;
        bus.mem_rsp_valid = rsp;
        bus.mem_rsp_data  = rsp ? (32'hA000_0000 | {2'b00, mq[0].addr}) : 32'h0;
        #1;
        exp_req = !rv && (eq.size() + mq.size() < DEPTH);
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, eq.size() > 0});
        chk("out_pc", bus.out_pc, eq.size() > 0 ? eq[0] : 32'h0);
        chk("out_instr", bus.out_instr, eq.size() > 0 ? (32'hA000_0000 | {2'b00, eq[0][31:2]}) : 32'h0);
        chk("mem_req_valid", {31'b0, bus.mem_req_valid}, {31'b0, exp_req});
        chk("mem_req_addr", {2'b00, bus.mem_req_addr}, {2'b00, fpc[31:2]});
        fire = exp_req && mr;
        pop  = ordy && eq.size() > 0;
        @(posedge clk);
        if (rsp) r = mq.pop_front();
        if (rv) begin
            eq.delete();
            ep++;
            fpc = {rp[31:2], 2'b00};
        end else begin
            if (pop) void'(eq.pop_front());
            if (rsp && r.ep == ep) eq.push_back({r.addr, 2'b00});
        end
        if (fire) begin
            mq.push_back('{fpc[31:2], ep, cyc + lat});
            fpc += 32'd4;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = 32'h0;
        bus.out_ready      = 1'b0;
        #1;
        chk("rst_req_valid", {31'b0, bus.mem_req_valid}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mq.delete();
        eq.delete();
        fpc = RESET_PC;
        cyc++;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_req_addr", {2'b00, bus.mem_req_addr}, {2'b00, RESET_PC[31:2]});
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
        step(1'b1, 32'h0000_0103, 1'b1, 1'b1, 3);
        chk("redir_addr", {2'b00, bus.mem_req_addr}, 32'h0000_0040);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1);
        chk("simul_empty", {31'b0, bus.out_valid}, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 2);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 6, $urandom_range(1, 4));
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end with a small prefetch queue, directly upstream of the SimpleRISC core's decode/execute.
- Issues sequential word fetches to an instruction memory with a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their PCs and presents them to the core on a valid/ready interface.
- On a core redirect (taken branch, call or ret) it flushes the queue and discards in-flight stale responses.

Parameters:
- DEPTH, 4: queue entries, which also sets the maximum combined in-flight requests plus queued entries. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset, synchronous, active-low.
- redirect_valid  in  1  core requests a fetch restart this cycle.
- redirect_pc  in  32  restart byte address; bits [1:0] ignored and treated as 0.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  30  word address, equal to fetch_pc[31:2].
- mem_rsp_valid  in  1  one response per accepted request, in order, at least 1 cycle after acceptance.
- mem_rsp_data  in  32  instruction word.
- out_valid  out  1  queue head valid.
- out_ready  in  1  core consumes the head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head byte PC.

Behaviour:
- Reset (rstn low at posedge):
  - fetch_pc = RESET_PC, rsp_pc = RESET_PC.
  - Queue empty; outstanding = 0; drop = 0.
  - Outputs: mem_req_valid = 0, out_valid = 0, out_instr = 0, out_pc = 0.
  - Reset mid-operation abandons all state. The memory side shares rstn, so no pre-reset responses follow.
- State:
  - count: 0..DEPTH.
  - outstanding: accepted requests with no response yet, 0..DEPTH.
  - drop: the subset of outstanding to discard.
  - count, outstanding and drop are each clog2(DEPTH+1) bits wide.
- Request issue:
  - mem_req_valid = !redirect_valid && (count + outstanding < DEPTH), combinational from state.
  - mem_req_addr = fetch_pc[31:2].
  - On mem_req_valid && mem_req_ready: fetch_pc += 4 (wraps mod 2^32) and outstanding++.
  - While ready is low, addr and valid stay stable unless a redirect arrives.
- Response:
  - Every mem_rsp_valid decrements outstanding.
  - If drop > 0: the data is discarded and drop is decremented.
  - Otherwise {rsp_pc, mem_rsp_data} is pushed to the tail and rsp_pc += 4.
  - Overflow cannot occur by credit rule. An overflow is an assertion failure.
- Output:
  - Show-ahead FIFO. out_valid = (count != 0); out_instr and out_pc show the head entry, and are 0 when empty.
  - Pop on out_valid && out_ready. Push and pop may occur in the same cycle.
  - A response received at cycle M is visible at out_valid in cycle M+1.
  - With 1-cycle memory latency and continuous out_ready, throughput is 1 instruction/cycle.
- Redirect (redirect_valid = 1 at posedge), which has priority over everything else:
  - Queue emptied, so count = 0. Any simultaneous pop or push is void.
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - No request is issued that cycle.
  - outstanding is updated normally.
  - drop = outstanding - (mem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - out_valid = 0 in the cycle after the redirect.
  - Back-to-back redirects: the last one wins, and drop is recomputed each time.
- Invariant: count + outstanding <= DEPTH, and drop <= outstanding.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, then RESET_PC = 0, memory latency 1, mem_rsp_data = 32'hA000_0000 | addr, out_ready = 1.
  - Required: out_pc sequence 0, 4, 8, 12… with one instruction per cycle after a 2-cycle fill; out_instr for pc 8 = 32'hA000_0002.
- Backpressure:
  - Stimulus: DEPTH = 4, out_ready = 0.
  - Required: exactly 4 requests accepted (addr 0..3), then mem_req_valid = 0 and count = 4, with out_pc = 0 held.
  - Raising out_ready drains pcs 0, 4, 8, 12 in order, and issue resumes at addr 4.
- Redirect with in-flight requests:
  - Stimulus: memory latency 3, 2 requests outstanding, redirect_pc = 32'h0000_0103.
  - Required: both stale responses dropped, and the next out_pc = 32'h0000_0100.
  - mem_req_addr = 30'h40 one cycle after the redirect.
- Simultaneous events:
  - Stimulus: redirect_valid, mem_rsp_valid and out_ready/out_valid all high in one cycle.
  - Required: queue empty next cycle, the response discarded, drop = outstanding - 1, and no extra entry appears.
- Memory stall:
  - Stimulus: mem_req_ready = 0 for 5 cycles.
  - Required: mem_req_valid = 1 and mem_req_addr constant, with fetch_pc advancing only on the handshake.
- Reset mid-stream:
  - Stimulus: pull rstn low for 1 cycle with a queue of 3.
  - Required: all outputs 0 next cycle, and refetch restarts at RESET_PC.
